// File: rtl/io_port_pkg.sv
// Shared definitions for the port-side I/O controller: interrupt FSM encoding,
// error flag bit positions and default widths.
package io_port_pkg;

   localparam int DEFAULT_DW    = 8;
   localparam int DEFAULT_DEPTH = 4;

   localparam int ERR_RX_UNDERFLOW = 0;
   localparam int ERR_TX_OVERFLOW  = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_WAIT_RD
   } int_state_t;

endpackage

// File: rtl/io_port_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with a separate occupancy counter so full and
// empty never alias; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
   import io_port_pkg::*;
#(
   parameter int DW    = DEFAULT_DW,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Port-side I/O controller: RX FIFO feeding the core's In_port with an
// interrupt request per byte, and TX FIFO draining Out_port writes to a sink.
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter int DW        = DEFAULT_DW,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int INT_PULSE = 2,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] ext_in_data,
   input  logic          ext_in_valid,
   output logic          ext_in_ready,
   output logic [DW-1:0] in_port,
   input  logic          in_rd,
   output logic          cpu_int,
   input  logic          int_en,
   input  logic [DW-1:0] out_port,
   input  logic          out_wr,
   output logic [DW-1:0] ext_out_data,
   output logic          ext_out_valid,
   input  logic          ext_out_ready,
   output logic [CW-1:0] rx_count,
   output logic [CW-1:0] tx_count,
   output logic [1:0]    err_flags
);

   localparam int PW = $clog2(INT_PULSE + 1);

   logic          rx_full;
   logic          rx_empty;
   logic          tx_full;
   logic          tx_empty;
   logic          rx_rd_ok;
   int_state_t    state;
   logic [PW-1:0] pulse_cnt;

   assign ext_in_ready  = !rst && !rx_full;
   assign ext_out_valid = !tx_empty;
   assign rx_rd_ok      = in_rd && !rx_empty;

   sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ext_in_valid && ext_in_ready),
      .pop   (in_rd),
      .din   (ext_in_data),
      .dout  (in_port),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_wr),
      .pop   (ext_out_valid && ext_out_ready),
      .din   (out_port),
      .dout  (ext_out_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // A full TX FIFO with the sink ready is popping this cycle, so only the
   // not-ready case actually drops the byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_flags <= '0;
      end else begin
         if (in_rd && rx_empty)
            err_flags[ERR_RX_UNDERFLOW] <= 1'b1;
         if (out_wr && tx_full && !ext_out_ready)
            err_flags[ERR_TX_OVERFLOW] <= 1'b1;
      end
   end

   // One request per serviced byte: a fixed-length pulse, then hold off until
   // the core performs a valid read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pulse_cnt <= '0;
         cpu_int   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rx_empty && int_en) begin
                  state     <= ST_ASSERT;
                  pulse_cnt <= PW'(INT_PULSE);
                  cpu_int   <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (pulse_cnt == PW'(1)) begin
                  state   <= ST_WAIT_RD;
                  cpu_int <= 1'b0;
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end
            ST_WAIT_RD: begin
               if (rx_rd_ok) state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               cpu_int <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: expected bytes are queued as they are
// driven and compared as the DUT presents them on in_port / ext_out_data.
module tb_io_port_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] ext_in_data;
   logic          ext_in_valid;
   logic          ext_in_ready;
   logic [DW-1:0] in_port;
   logic          in_rd;
   logic          cpu_int;
   logic          int_en;
   logic [DW-1:0] out_port;
   logic          out_wr;
   logic [DW-1:0] ext_out_data;
   logic          ext_out_valid;
   logic          ext_out_ready;
   logic [2:0]    rx_count;
   logic [2:0]    tx_count;
   logic [1:0]    err_flags;

   int            tests_run    = 0;
   int            tests_failed = 0;
   int            int_pulses   = 0;
   logic          int_prev     = 1'b0;
   logic [DW-1:0] rx_exp[$];
   logic [DW-1:0] tx_exp[$];

   io_port_ctrl #(.DW(DW), .DEPTH(DEPTH), .INT_PULSE(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .ext_in_data   (ext_in_data),
      .ext_in_valid  (ext_in_valid),
      .ext_in_ready  (ext_in_ready),
      .in_port       (in_port),
      .in_rd         (in_rd),
      .cpu_int       (cpu_int),
      .int_en        (int_en),
      .out_port      (out_port),
      .out_wr        (out_wr),
      .ext_out_data  (ext_out_data),
      .ext_out_valid (ext_out_valid),
      .ext_out_ready (ext_out_ready),
      .rx_count      (rx_count),
      .tx_count      (tx_count),
      .err_flags     (err_flags)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives all stimulus except in_rd and records what the DUT should accept.
   task automatic applyStimulus(input logic rx_v, input logic [DW-1:0] rx_d,
                                input logic wr, input logic [DW-1:0] wr_d,
                                input logic o_rdy);
      ext_in_valid  = rx_v;
      ext_in_data   = rx_d;
      out_wr        = wr;
      out_port      = wr_d;
      ext_out_ready = o_rdy;
      if (!rst && rx_v && rx_exp.size() < DEPTH) rx_exp.push_back(rx_d);
      if (!rst && wr && (tx_exp.size() < DEPTH || (o_rdy && tx_exp.size() > 0)))
         tx_exp.push_back(wr_d);
   endtask

   task automatic readRx();
      logic [DW-1:0] exp_byte;
      in_rd = 1'b1;
      @(negedge clk);
      exp_byte = (rx_exp.size() > 0) ? rx_exp.pop_front() : '0;
      checkOutput("in_port", 32'(in_port), 32'(exp_byte));
      cycle();
      in_rd = 1'b0;
   endtask

   task automatic waitInt(input logic level);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (cpu_int === level);
         cycle();
      end
      checkOutput(level ? "int_rise_wait" : "int_fall_wait", 32'(seen), 32'd1);
   endtask

   always @(negedge clk) begin
      if (cpu_int && !int_prev) int_pulses++;
      int_prev = cpu_int;
   end

   always @(negedge clk) begin
      if (!rst && ext_out_valid && ext_out_ready) begin
         if (tx_exp.size() == 0) checkOutput("tx_unexpected", 32'(ext_out_data), 32'hFFFF);
         else checkOutput("ext_out_data", 32'(ext_out_data), 32'(tx_exp.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [DW-1:0] fill[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic          seen_int[5];
      logic          exp_int[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int            pulses_before;

      rst    = 1'b1;
      in_rd  = 1'b0;
      int_en = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) cycle();
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(ext_in_ready), 32'd0);
      checkOutput("rst_cpu_int", 32'(cpu_int), 32'd0);
      checkOutput("rst_out_valid", 32'(ext_out_valid), 32'd0);
      checkOutput("rst_in_port", 32'(in_port), 32'd0);
      checkOutput("rst_out_data", 32'(ext_out_data), 32'd0);
      checkOutput("rst_counts", {rx_count, tx_count}, 32'd0);
      checkOutput("rst_err", 32'(err_flags), 32'd0);
      cycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 32'(ext_in_ready), 32'd1);
      cycle();

      // Single RX byte: pulse timing relative to the push edge.
      int_en = 1'b1;
      applyStimulus(1'b1, 8'hA5, 1'b0, '0, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         seen_int[k] = cpu_int;
         if (k == 0) begin
            checkOutput("single_in_port", 32'(in_port), 32'hA5);
            checkOutput("single_rx_count", 32'(rx_count), 32'd1);
         end
         cycle();
      end
      for (int k = 0; k < 5; k++) checkOutput($sformatf("single_int_c%0d", k),
                                              32'(seen_int[k]), 32'(exp_int[k]));
      readRx();
      pulses_before = int_pulses;
      @(negedge clk);
      checkOutput("single_rx_empty", 32'(rx_count), 32'd0);
      for (int k = 0; k < 5; k++) cycle();
      checkOutput("single_no_reint", int_pulses - pulses_before, 32'd0);

      // RX fill, back-pressure, then one read per serviced interrupt.
      int_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, fill[i], 1'b0, '0, 1'b0);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 8'h55, 1'b0, '0, 1'b0);
         @(negedge clk);
         checkOutput("fill_ready_low", 32'(ext_in_ready), 32'd0);
         checkOutput("fill_rx_count", 32'(rx_count), 32'd4);
         cycle();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      pulses_before = int_pulses;
      int_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waitInt(1'b1);
         waitInt(1'b0);
         readRx();
      end
      for (int k = 0; k < 6; k++) cycle();
      checkOutput("burst_int_pulses", int_pulses - pulses_before, 32'd4);
      checkOutput("burst_rx_count", 32'(rx_count), 32'd0);

      // TX path: buffer two bytes, then drain back to back.
      applyStimulus(1'b0, '0, 1'b1, 8'h7F, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b1, 8'h02, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("tx_count_2", 32'(tx_count), 32'd2);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkOutput("tx_head_7f", 32'(ext_out_data), 32'h7F);
      cycle();
      @(negedge clk);
      checkOutput("tx_head_02", 32'(ext_out_data), 32'h02);
      cycle();
      @(negedge clk);
      checkOutput("tx_drained", 32'(ext_out_valid), 32'd0);
      cycle();

      // TX overflow: drop when not draining, accept when draining.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 8'hA0 + 8'(i), 1'b0);
         cycle();
      end
      applyStimulus(1'b0, '0, 1'b1, 8'hEE, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("ovf_err", 32'(err_flags), 32'b10);
      checkOutput("ovf_tx_count", 32'(tx_count), 32'd4);
      cycle();
      applyStimulus(1'b0, '0, 1'b1, 8'hFF, 1'b1);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("ovf_accept_count", 32'(tx_count), 32'd4);
      checkOutput("ovf_head", 32'(ext_out_data), 32'hA1);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("ovf_drained", 32'(ext_out_valid), 32'd0);
      checkOutput("ovf_queue_left", tx_exp.size(), 32'd0);
      cycle();

      // Underflow with interrupts disabled, then late enable.
      int_en = 1'b0;
      readRx();
      @(negedge clk);
      checkOutput("unf_err", 32'(err_flags), 32'b11);
      cycle();
      pulses_before = int_pulses;
      applyStimulus(1'b1, 8'h05, 1'b0, '0, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 5; k++) cycle();
      checkOutput("dis_no_int", int_pulses - pulses_before, 32'd0);
      int_en = 1'b1;
      @(negedge clk);
      checkOutput("en_int_before", 32'(cpu_int), 32'd0);
      cycle();
      @(negedge clk);
      checkOutput("en_int_after", 32'(cpu_int), 32'd1);
      cycle();
      waitInt(1'b0);
      readRx();

      // Reset in the middle of traffic discards everything.
      applyStimulus(1'b1, 8'h99, 1'b1, 8'h33, 1'b0);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      rst = 1'b1;
      rx_exp.delete();
      tx_exp.delete();
      pulses_before = int_pulses;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("mid_rst_ready", 32'(ext_in_ready), 32'd0);
         cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_cpu_int", 32'(cpu_int), 32'd0);
      checkOutput("mid_rst_out_valid", 32'(ext_out_valid), 32'd0);
      checkOutput("mid_rst_counts", {rx_count, tx_count}, 32'd0);
      checkOutput("mid_rst_err", 32'(err_flags), 32'd0);
      checkOutput("mid_rst_in_port", 32'(in_port), 32'd0);
      checkOutput("mid_rst_ready_back", 32'(ext_in_ready), 32'd1);
      cycle();
      for (int k = 0; k < 5; k++) cycle();
      checkOutput("mid_rst_no_int", int_pulses - pulses_before, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Port-side I/O controller that sits on the far side of the processor's In_port / Out_port / int pins (the role the top-level bench plays today).
- RX path: buffers bytes from an external valid/ready source and presents them on In_port, raising the interrupt line to request service.
- TX path: captures bytes the core writes to Out_port and drains them to an external valid/ready sink.
- Instantiated next to top; replaces ad-hoc bench driving of In_port/int.

Parameters:
- DW, 8, data width of all ports.
- DEPTH, 4, entries per FIFO; power of 2, at least 2.
- INT_PULSE, 2, cycles cpu_int stays high per request; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ext_in_data  in  DW  byte from external source.
- ext_in_valid  in  1  source has a byte.
- ext_in_ready  out  1  RX FIFO can accept (= !rx_full).
- in_port  out  DW  to core In_port; RX FIFO head.
- in_rd  in  1  core IN-instruction strobe, one cycle per read.
- cpu_int  out  1  to core int.
- int_en  in  1  interrupt request enable.
- out_port  in  DW  from core Out_port.
- out_wr  in  1  core OUT-instruction strobe.
- ext_out_data  out  DW  TX FIFO head.
- ext_out_valid  out  1  TX FIFO non-empty.
- ext_out_ready  in  1  sink accepts.
- rx_count  out  clog2(DEPTH)+1  RX occupancy.
- tx_count  out  clog2(DEPTH)+1  TX occupancy.
- err_flags  out  2  sticky: [0] RX underflow, [1] TX overflow.

Behaviour:
- Reset (rst=1 at posedge) clears:
  - both FIFOs, pointers, counts and err_flags;
  - FSM returns to IDLE.
- Reset outputs:
  - cpu_int=0, ext_in_ready=0 while rst is high, then 1;
  - ext_out_valid=0, in_port=0, ext_out_data=0, counts=0.
- Reset mid-operation discards all buffered data; no partial request survives.
- RX push: occurs when ext_in_valid && ext_in_ready at posedge.
- RX show-ahead:
  - in_port is combinationally the head entry when non-empty; 0x00 when empty.
  - A pushed byte is visible on in_port the cycle after the push.
- RX pop: in_rd pops the head at posedge.
  - in_rd while empty is ignored and sets err_flags[0].
  - Push and pop in the same cycle: both take effect, count unchanged.
  - Push into a full FIFO cannot occur because ready is low.
- TX push: out_wr writes out_port at posedge.
  - out_wr while full with ext_out_ready=0: byte dropped, err_flags[1] set.
  - out_wr while full with an ext pop in the same cycle: accepted.
- TX pop: occurs when ext_out_valid && ext_out_ready. ext_out_data is the head (show-ahead).
- Pointers wrap modulo DEPTH. Count is tracked separately so the full and empty states are unambiguous.
- Interrupt FSM, state IDLE:
  - moves to ASSERT when rx_count!=0 && int_en; a pulse counter loads INT_PULSE.
- Interrupt FSM, state ASSERT:
  - cpu_int=1; counter decrements;
  - moves to WAIT_RD when the counter reaches 1, so the pulse is exactly INT_PULSE cycles.
- Interrupt FSM, state WAIT_RD:
  - cpu_int=0; moves to IDLE on the first valid in_rd (FIFO non-empty).
  - If bytes remain, the next request starts from IDLE one cycle later.
- int_en deasserted in ASSERT: pulse completes anyway. int_en deasserted in WAIT_RD: no effect.
- An in_rd during ASSERT pops normally. The FSM then goes ASSERT to WAIT_RD, and the next valid in_rd returns it to IDLE.
- One request per serviced byte; never more than one outstanding request.
- Latency: push to first cpu_int high is 2 cycles. Cycle 1 is the FIFO write; cycle 2 is the IDLE to ASSERT registration.

Decomposition:
- Shared package io_port_pkg:
  - FSM state encoding (IDLE, ASSERT, WAIT_RD);
  - err_flags bit index constants;
  - default DW/DEPTH.
- Sub-module sync_fifo, instantiated twice (RX, TX), parameterized by DW and DEPTH, with ports:
  - push, pop, din, dout (show-ahead);
  - full, empty, count.
- The top handles the FSM, strobes and error flags.

Test Plan:
- Reset check: pulse rst for 3 cycles mid-traffic -> cpu_int=0, ext_out_valid=0, both counts 0, err_flags=00.
- Single RX byte: int_en=1, push 0xA5 -> cpu_int high for exactly 2 cycles starting 2 cycles after the push; in_port=0xA5; an in_rd pulse then gives rx_count=0 and FSM IDLE with no further int.
- RX fill and burst: push 0x11,0x22,0x33,0x44, then a 5th with valid held -> ext_in_ready=0 after the 4th. Then issue 4 in_rd pulses, one per serviced interrupt -> in_port sequence 11,22,33,44, exactly 4 cpu_int pulses, wrap-around exercised.
- TX path: out_wr 0x7F, 0x02 with ext_out_ready=0 -> tx_count=2; raise ready -> ext_out_data 7F then 02 on consecutive cycles.
- TX overflow: fill 4 with ready=0, out_wr 0xEE -> dropped, err_flags[1]=1. Repeat when full with ready=1 in the same cycle -> accepted, tx_count stays 4.
- Underflow plus disabled interrupt: int_en=0, in_rd on empty RX -> err_flags[0]=1. Push 0x05 -> no cpu_int. Set int_en=1 -> pulse begins 1 cycle later.
